axis_vector_dispatcher: RTL and testbench
=========================================

Name: axis_vector_dispatcher

Overview:
- Host-side injection endpoint for the MLP mesh.
- Accepts input-vector words from a simple FIFO-write interface, buffers them, and emits each as an AXI-Stream flit toward one fixed first-layer MVM node.
- Output tdata is the mesh flit width: payload in the low DATAW bits, MVM sideband (USERW bits) appended above it.
- One instance per first-layer MVM.

Parameters:
- DATAW, 512, payload bits per vector word.
- USERW, 75, sideband bits appended above the payload in tdata.
- IDW, 2, tid width.
- DESTW, 4, tdest width (mesh node id).
- DESTNODE, 0, destination node id driven on tdest.
- FIFO_DEPTH, 8, buffered words; power of two, at least 2.
- INPUT_OP, 2'b10, opcode placed in the sideband to mark an input-vector flit.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- data_fifo_wen, input, 1, write strobe.
- data_fifo_wdata, input, DATAW, vector word.
- data_last, input, 1, marks the final word of the stream; sampled with the write.
- data_fifo_rdy, output, 1, FIFO can accept a write this cycle.
- axis_tx_tvalid, output, 1, flit valid.
- axis_tx_tready, input, 1, mesh accepts the flit.
- axis_tx_tdata, output, DATAW+USERW, flit data.
- axis_tx_tlast, output, 1, last flit.
- axis_tx_tid, output, IDW, stream id.
- axis_tx_tdest, output, DESTW, destination node.

Behaviour:
- Reset (asynchronous assert on rst_n low, synchronous release):
  - FIFO empty; pointers and count = 0.
  - axis_tx_tvalid = 0; axis_tx_tdata/tlast = 0.
  - data_fifo_rdy = 1 once reset is released; held 0 while in reset.
- Storage: FIFO_DEPTH entries of {last, wdata}, circular with pointer wrap at FIFO_DEPTH.
- data_fifo_rdy = (count != FIFO_DEPTH). Depends only on the registered count, with no same-cycle read bypass.
- Write: accepted when data_fifo_wen && data_fifo_rdy. A wen while not ready is silently dropped.
- Output:
  - Show-ahead FIFO; axis_tx_tvalid = (count != 0).
  - tdata[DATAW-1:0] = head word.
  - tdata[DATAW+10:DATAW+9] = INPUT_OP; all other sideband bits 0 (rf_en = 0, addr = 0).
  - tlast = head's stored last bit.
  - tid = 0; tdest = DESTNODE constant.
- Read: pop when tvalid && tready.
- Latency: a word written at edge N appears on tvalid after edge N (visible in cycle N+1) if the FIFO was empty.
- Backpressure: while tvalid && !tready, all tx outputs hold stable; no reordering, no drop.
- Simultaneous push and pop in the same cycle: count unchanged; both take effect. At full, push is refused because rdy = 0, and the pop still occurs.
- Throughput: one flit per cycle sustained when tready stays high and writes are continuous.
- Ordering: strict FIFO; tlast travels with its word.
- Reset mid-operation: contents discarded; tvalid drops immediately (asynchronous).

Test Plan:
- Reset: hold rst_n = 0 -> tvalid = 0, rdy = 0. Release -> rdy = 1, tvalid = 0.
- Single word:
  - Stimulus: write 0x3, last = 1, tready = 1.
  - Response: next cycle tvalid = 1, tdata[511:0] = 0x3, tdata[522:521] = 2'b10, tlast = 1, tdest = DESTNODE, tid = 0. Popped that cycle, then tvalid = 0.
- Burst:
  - Stimulus: 4 back-to-back writes 0x3, 0x6, 0x9, 0xc, last on the 4th; tready = 1.
  - Response: 4 consecutive flits in order, tlast only on 0xc.
- Backpressure/full:
  - Stimulus: tready = 0, write 8 words.
  - Response: rdy falls after the 8th write; a 9th wen is dropped.
  - Then raise tready -> exactly the 8 words emerge in order, and rdy returns to 1 after the first pop.
- Stall stability: tready toggled randomly -> tdata/tlast unchanged while tvalid && !tready; no duplicates.
- Reset mid-stream: assert rst_n low with 3 words queued -> tvalid = 0 immediately; after release the FIFO is empty and the next write is emitted normally.

Source files
------------

// File: rtl/axis_vector_dispatcher.sv
// Host-side injection endpoint: buffers input-vector words in a show-ahead FIFO
// and emits each one as an AXI-Stream flit to a single first-layer MVM node.
module axis_vector_dispatcher #(
    parameter int               DATAW      = 512,
    parameter int               USERW      = 75,
    parameter int               IDW        = 2,
    parameter int               DESTW      = 4,
    parameter logic [DESTW-1:0] DESTNODE   = '0,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [1:0]       INPUT_OP   = 2'b10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_fifo_wen,
    input  logic [DATAW-1:0]       data_fifo_wdata,
    input  logic                   data_last,
    output logic                   data_fifo_rdy,
    output logic                   axis_tx_tvalid,
    input  logic                   axis_tx_tready,
    output logic [DATAW+USERW-1:0] axis_tx_tdata,
    output logic                   axis_tx_tlast,
    output logic [IDW-1:0]         axis_tx_tid,
    output logic [DESTW-1:0]       axis_tx_tdest
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Sideband: opcode at [10:9], rf_en and addr fields left at zero.
    localparam logic [USERW-1:0] SIDEBAND = USERW'(INPUT_OP) << 9;

    logic [DATAW:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rdy_en_q;
    logic            push, pop;
    logic [DATAW:0]  head;

    // rdy_en_q keeps the write side closed until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    assign data_fifo_rdy  = rdy_en_q && (count_q != FULL_CNT);
    assign axis_tx_tvalid = (count_q != '0);
    assign push           = data_fifo_wen && data_fifo_rdy;
    assign pop            = axis_tx_tvalid && axis_tx_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {data_last, data_fifo_wdata};
    end

    // Outputs are forced to zero when empty so reset leaves tdata/tlast clean.
    assign head          = mem_q[rd_ptr_q];
    assign axis_tx_tdata = axis_tx_tvalid ? {SIDEBAND, head[DATAW-1:0]} : '0;
    assign axis_tx_tlast = axis_tx_tvalid && head[DATAW];
    assign axis_tx_tid   = '0;
    assign axis_tx_tdest = DESTNODE;

endmodule

// File: tb/tb_axis_vector_dispatcher.sv
// Directed self-checking bench for axis_vector_dispatcher.
module tb_axis_vector_dispatcher;
    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int IDW   = 2;
    localparam int DESTW = 4;
    localparam int FW    = DATAW + USERW;
    localparam logic [DESTW-1:0] DEST = 4'd5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wen;
    logic [DATAW-1:0] wdata;
    logic             last;
    logic             rdy;
    logic             tvalid;
    logic             tready;
    logic [FW-1:0]    tdata;
    logic             tlast;
    logic [IDW-1:0]   tid;
    logic [DESTW-1:0] tdest;

    int n_chk  = 0;
    int n_fail = 0;

    axis_vector_dispatcher #(
        .DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW),
        .DESTNODE(DEST), .FIFO_DEPTH(8), .INPUT_OP(2'b10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_fifo_wen(wen), .data_fifo_wdata(wdata), .data_last(last),
        .data_fifo_rdy(rdy),
        .axis_tx_tvalid(tvalid), .axis_tx_tready(tready),
        .axis_tx_tdata(tdata), .axis_tx_tlast(tlast),
        .axis_tx_tid(tid), .axis_tx_tdest(tdest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] flit(input logic [DATAW-1:0] d);
        logic [FW-1:0] f;
        f = '0;
        f[DATAW-1:0] = d;
        f[DATAW+10 -: 2] = 2'b10;
        return f;
    endfunction

    logic [DATAW-1:0] words [6];
    int idx;

    initial begin
        rst_n = 1'b0; wen = 1'b0; wdata = '0; last = 1'b0; tready = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_tvalid", FW'(tvalid), '0);
        chk("rst_rdy",    FW'(rdy),    '0);
        chk("rst_tdata",  tdata,       '0);
        chk("rst_tlast",  FW'(tlast),  '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy",    FW'(rdy),    FW'(1));
        chk("rel_tvalid", FW'(tvalid), '0);

        // Single word
        wen = 1'b1; wdata = DATAW'(3); last = 1'b1; tready = 1'b1;
        @(negedge clk);
        wen = 1'b0; last = 1'b0;
        chk("single_tvalid", FW'(tvalid), FW'(1));
        chk("single_tdata",  tdata,       flit(DATAW'(3)));
        chk("single_tlast",  FW'(tlast),  FW'(1));
        chk("single_tdest",  FW'(tdest),  FW'(DEST));
        chk("single_tid",    FW'(tid),    '0);
        @(negedge clk);
        chk("single_drain", FW'(tvalid), '0);

        // Burst of 4 with concurrent push/pop
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                chk("burst_tvalid", FW'(tvalid), FW'(1));
                chk("burst_tdata",  tdata,       flit(DATAW'(3 * i)));
                chk("burst_tlast",  FW'(tlast),  FW'(i == 4));
            end
            if (i < 4) begin
                wen = 1'b1; wdata = DATAW'(3 * (i + 1)); last = (i == 3);
            end else begin
                wen = 1'b0; last = 1'b0;
            end
            @(negedge clk);
        end
        chk("burst_drain", FW'(tvalid), '0);

        // Backpressure to full
        tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("fill_rdy", FW'(rdy), FW'(1));
            wen = 1'b1; wdata = DATAW'(32'h100 + i); last = (i == 7);
            @(negedge clk);
        end
        chk("full_rdy",   FW'(rdy),    '0);
        chk("full_head",  tdata,       flit(DATAW'(32'h100)));
        wdata = DATAW'(32'hDEAD); last = 1'b0;   // dropped write
        @(negedge clk);
        chk("full_rdy_hold", FW'(rdy), '0);
        wen = 1'b0;
        tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_tvalid", FW'(tvalid), FW'(1));
            chk("drain_tdata",  tdata,       flit(DATAW'(32'h100 + j)));
            chk("drain_tlast",  FW'(tlast),  FW'(j == 7));
            if (j == 1) chk("drain_rdy", FW'(rdy), FW'(1));
            @(negedge clk);
        end
        chk("drain_empty", FW'(tvalid), '0);

        // Random stall stability
        tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            words[i] = DATAW'(32'hA000 + 7 * i);
            wen = 1'b1; wdata = words[i]; last = (i == 5);
            @(negedge clk);
        end
        wen = 1'b0; last = 1'b0;
        idx = 0;
        for (int c = 0; c < 80 && idx < 6; c++) begin
            if (tvalid) begin
                chk("stall_tdata", tdata,      flit(words[idx]));
                chk("stall_tlast", FW'(tlast), FW'(idx == 5));
            end
            tready = 1'($urandom_range(0, 1));
            if (tvalid && tready) idx++;
            @(negedge clk);
        end
        chk("stall_count", FW'(idx), FW'(6));
        chk("stall_empty", FW'(tvalid), '0);

        // Reset mid-stream
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; wdata = DATAW'(32'h77 + i); last = 1'b0;
            @(negedge clk);
        end
        wen = 1'b0;
        chk("mid_tvalid_pre", FW'(tvalid), FW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_tvalid_async", FW'(tvalid), '0);
        chk("mid_rdy_async",    FW'(rdy),    '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy",    FW'(rdy),    FW'(1));
        chk("mid_rel_tvalid", FW'(tvalid), '0);
        wen = 1'b1; wdata = DATAW'(32'h55); last = 1'b0; tready = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        chk("post_tdata", tdata,      flit(DATAW'(32'h55)));
        chk("post_tlast", FW'(tlast), '0);
        @(negedge clk);
        chk("post_empty", FW'(tvalid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
